// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM bank: register selects, CTRL bit positions,
// and the counter direction type used by center-aligned channels.
package pwm_pkg;

    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_DUTY   = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CENTER = 1;
    localparam int CTRL_INV    = 2;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period and duty, up or up/down counter,
// compare, and registered output plus period-boundary pulse.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_per,
    input  logic             wr_duty,
    input  logic             wr_ctrl,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             sync,
    output logic             pwm_out,
    output logic             cyc_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_sh_q, per_sh_d;
    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] per_act_q, per_act_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [2:0]       ctrl_q, ctrl_d;
    dir_e             dir_q, dir_d;
    logic             run_q, run_d;
    logic             pwm_q, pwm_d;
    logic             cyc_q, cyc_d;

    logic [CNT_W-1:0] per_m1;
    logic             en;
    logic             raw;
    logic             center_bnd;

    always_comb begin
        cnt_d      = cnt_q;
        per_sh_d   = per_sh_q;
        duty_sh_d  = duty_sh_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        ctrl_d     = ctrl_q;
        dir_d      = dir_q;
        run_d      = run_q;
        cyc_d      = 1'b0;

        if (wr_per)  per_sh_d  = wr_data;
        if (wr_duty) duty_sh_d = wr_data;
        if (wr_ctrl) ctrl_d    = wr_data[2:0];

        en         = ctrl_q[CTRL_EN];
        per_m1     = (per_act_q != '0) ? per_act_q - CNT_W'(1) : '0;
        raw        = en && (per_act_q != '0) && (cnt_q < duty_act_q);
        center_bnd = (cnt_q == '0) && ((dir_q == DOWN) || !run_q);

        if (!en) begin
            cnt_d      = '0;
            dir_d      = UP;
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
            run_d      = 1'b0;
        end else begin
            run_d = 1'b1;
            if (sync) begin
                cnt_d      = '0;
                dir_d      = UP;
                per_act_d  = per_sh_q;
                duty_act_d = duty_sh_q;
            end else if (per_act_q == '0) begin
                // Idle period: keep following the shadow so a later PERIOD write can start it.
                cnt_d      = '0;
                dir_d      = UP;
                per_act_d  = per_sh_q;
                duty_act_d = duty_sh_q;
            end else if (!ctrl_q[CTRL_CENTER] || (per_act_q == CNT_W'(1))) begin
                dir_d = UP;
                if (cnt_q >= per_m1) begin
                    cnt_d      = '0;
                    per_act_d  = per_sh_q;
                    duty_act_d = duty_sh_q;
                    cyc_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (center_bnd) begin
                // The boundary cycle itself sits at 0, so the next period resumes at 1.
                per_act_d  = per_sh_q;
                duty_act_d = duty_sh_q;
                cyc_d      = 1'b1;
                dir_d      = UP;
                cnt_d      = (per_sh_q > CNT_W'(1)) ? CNT_W'(1) : '0;
            end else if (dir_q == DOWN) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (cnt_q >= per_m1) begin
                dir_d = DOWN;
                cnt_d = per_m1 - CNT_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        pwm_d = raw ^ ctrl_q[CTRL_INV];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            per_act_q  <= '0;
            duty_act_q <= '0;
            ctrl_q     <= '0;
            dir_q      <= UP;
            run_q      <= 1'b0;
            pwm_q      <= 1'b0;
            cyc_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            per_act_q  <= per_act_d;
            duty_act_q <= duty_act_d;
            ctrl_q     <= ctrl_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
            pwm_q      <= pwm_d;
            cyc_q      <= cyc_d;
        end
    end

    assign pwm_out = pwm_q;
    assign cyc_end = cyc_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: decodes the single register-write port into
// per-channel strobes and fans the global sync out to every channel.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 28,
    parameter int CH_W   = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              sync,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] cyc_end
);

    logic wr_per_sel, wr_duty_sel, wr_ctrl_sel;

    assign wr_per_sel  = wr_en && (wr_sel == SEL_PERIOD);
    assign wr_duty_sel = wr_en && (wr_sel == SEL_DUTY);
    assign wr_ctrl_sel = wr_en && (wr_sel == SEL_CTRL);

    // Indices at or above NUM_CH match no instance, so such writes fall away.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic hit;
        assign hit = (wr_ch == CH_W'(i));

        pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (CLK),
            .rst_n   (RST_N),
            .wr_per  (wr_per_sel && hit),
            .wr_duty (wr_duty_sel && hit),
            .wr_ctrl (wr_ctrl_sel && hit),
            .wr_data (wr_data),
            .sync    (sync),
            .pwm_out (pwm_out[i]),
            .cyc_end (cyc_end[i])
        );
    end

endmodule
